apb_timer_slave: RTL and testbench
==================================

// Module: apb_timer_slave
// PURPOSE
//  APB completer on one PSEL bit of the APB bus: programmable down-counting timer with wait-state insertion.
//  Decodes APB setup/access phases, drives PREADY/PRDATA back to the requester, raises irq on expiry.
//  Sits directly downstream of the APB bus interface; the top level connects one PSEL bit to PSEL here.
// PARAMETERS
//  WAIT_STATES  0   PREADY-low cycles inserted in every ACCESS phase (0..15)
//  CNT_W        32  counter/LOAD width; registers zero-extended to 32b on read
// PORTS
//  PCLK      in   1      bus clock; all logic on posedge
//  PRESET    in   1      synchronous, active-high reset
//  PADDR     in   32     byte address; only PADDR[4:2] decoded
//  PSEL      in   1      select (one bit of the 16-bit bus PSEL)
//  PENABLE   in   1      access phase
//  PWRITE    in   1      1=write, 0=read
//  PWDATA    in   32     write data
//  PRDATA    out  32     read data, valid in completing cycle only, else 0
//  PREADY    out  1      transfer completes when PSEL&PENABLE&PREADY
//  irq       out  1      STATUS.EXPIRED & CTRL.IRQ_EN
//  tick_out  out  1      one-cycle pulse on each expiry
// BEHAVIOUR
//  Reset: state=IDLE, PREADY=0, PRDATA=0, irq=0, tick_out=0, all regs 0.
//  Register map (offset):
//   0x00 CTRL   RW [0]EN [1]AUTO_RELOAD [2]IRQ_EN
//   0x04 LOAD   RW; write also loads COUNT in the same cycle
//   0x08 COUNT  RO
//   0x0C STATUS [0]EXPIRED, W1C
//   0x10 PRESC  RW (present only with APB_TIMER_PRESCALE_EN)
//   Other offsets: read 0, write ignored; transfer still completes normally.
//  Bus FSM IDLE->ACCESS->IDLE:
//   IDLE: PSEL=1,PENABLE=0 -> ACCESS, wcnt<=WAIT_STATES.
//   ACCESS: PREADY=(wcnt==0); wcnt decrements while >0.
//   ACCESS completing cycle: PSEL&PENABLE&PREADY -> write commits at clock edge, PRDATA=reg; next state IDLE.
//   PSEL dropped in ACCESS -> IDLE, no commit.
//  Latency: WAIT_STATES=0 completes in the first ACCESS cycle (2-cycle transfer).
//  Back-to-back transfers are supported (new setup in the cycle after completion).
//  Timer: with EN=1 a tick occurs every (PRESC+1) cycles; PRESC is fixed at 0 when the macro is off.
//   On tick with COUNT!=0: COUNT--.
//   On tick with COUNT==0: EXPIRED<=1, tick_out pulses.
//    AUTO_RELOAD=1: COUNT<=LOAD.
//    AUTO_RELOAD=0: EN<=0 (one-shot), COUNT stays 0.
//  Simultaneous events:
//   APB write to LOAD/COUNT-affecting reg in a tick cycle: write wins.
//   W1C of EXPIRED in the same cycle as a new expiry: set wins.
//   EN write 0->1 clears the prescaler count.
//  Reset mid-transfer: the transfer is aborted, all outputs return to reset values next cycle.
// CONFIGURATION
//  APB_TIMER_PRESCALE_EN defined: 16-bit PRESC reg at 0x10, tick every PRESC+1 cycles.
//  Not defined: no PRESC reg, 0x10 reads 0, tick every cycle when EN=1.
// STRUCTURE
//  apb_timer_pkg: register offset localparams, CTRL bit indices, bus FSM state enum (IDLE, ACCESS).
//  Sub-module apb_timer_core: prescaler, counter, expiry/reload logic.
//  apb_timer_slave: APB FSM, wait counter, register decode; instantiates the core.
// TESTING
//  1. Reset, then read all offsets -> PRDATA=0 each; PREADY high exactly in the first ACCESS cycle (WAIT_STATES=0).
//  2. WAIT_STATES=3, write LOAD=5 -> PREADY low 3 ACCESS cycles then high; COUNT reads 5.
//  3. LOAD=2, CTRL=0x5 (EN, IRQ_EN) -> COUNT 2,1,0; expiry on the next tick: tick_out pulse, irq=1, EN=0, COUNT=0.
//  4. LOAD=1, CTRL=0x3 -> expiry every 2 ticks, COUNT reloads 1; W1C STATUS in an expiry cycle -> EXPIRED stays 1.
//  5. PSEL dropped mid-wait on a write to LOAD=9 -> LOAD unchanged, FSM returns to IDLE.
//  6. With APB_TIMER_PRESCALE_EN: PRESC=3, LOAD=1, EN=1 -> COUNT decrements every 4 cycles; without the macro, 0x10 reads 0.

Source files
------------

// File: rtl/apb_timer_pkg.sv
// Shared definitions for the APB timer completer: register offsets, CTRL bit
// positions, widths and the bus FSM state type.
package apb_timer_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned CTRL_W  = 3;
    localparam int unsigned PRESC_W = 16;
    localparam int unsigned WCNT_W  = 4;

    // Word index taken from PADDR[4:2]
    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_LOAD   = 3'd1;
    localparam logic [2:0] OFF_COUNT  = 3'd2;
    localparam logic [2:0] OFF_STATUS = 3'd3;
    localparam logic [2:0] OFF_PRESC  = 3'd4;

    localparam int unsigned CTRL_EN          = 0;
    localparam int unsigned CTRL_AUTO_RELOAD = 1;
    localparam int unsigned CTRL_IRQ_EN      = 2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } bus_state_e;

endpackage

// File: rtl/apb_timer_core.sv
// Timer datapath: prescaler, down counter, expiry flag and reload/one-shot handling.
// PRESC register exists only when APB_TIMER_PRESCALE_EN is defined.
module apb_timer_core
    import apb_timer_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_ctrl,
    input  logic                wr_load,
    input  logic                wr_status,
    input  logic                wr_presc,
    input  logic [DATA_W-1:0]   wdata,
    output logic [CTRL_W-1:0]   ctrl,
    output logic [CNT_W-1:0]    load_val,
    output logic [CNT_W-1:0]    count,
    output logic                expired,
    output logic [PRESC_W-1:0]  presc,
    output logic                tick_out
);

    logic [PRESC_W-1:0] presc_cnt;
    logic               tick;
    logic               expire;

`ifdef APB_TIMER_PRESCALE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
        end else if (wr_presc) begin
            presc <= PRESC_W'(wdata);
        end
    end
`else
    logic unused_wr_presc;
    assign unused_wr_presc = wr_presc;
    assign presc           = '0;
`endif

    assign tick   = ctrl[CTRL_EN] && (presc_cnt == presc);
    assign expire = tick && (count == '0);

    // Register writes take priority over timer-driven updates in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_cnt <= '0;
            ctrl      <= '0;
            load_val  <= '0;
            count     <= '0;
            expired   <= 1'b0;
            tick_out  <= 1'b0;
        end else begin
            if (!ctrl[CTRL_EN] || tick) begin
                presc_cnt <= '0;
            end else begin
                presc_cnt <= presc_cnt + PRESC_W'(1);
            end

            if (wr_ctrl) begin
                ctrl <= CTRL_W'(wdata);
            end else if (expire && !ctrl[CTRL_AUTO_RELOAD]) begin
                ctrl[CTRL_EN] <= 1'b0;
            end

            if (wr_load) begin
                load_val <= CNT_W'(wdata);
                count    <= CNT_W'(wdata);
            end else if (tick) begin
                if (count != '0) begin
                    count <= count - CNT_W'(1);
                end else if (ctrl[CTRL_AUTO_RELOAD]) begin
                    count <= load_val;
                end
            end

            // A fresh expiry beats a simultaneous write-one-to-clear
            if (expire) begin
                expired <= 1'b1;
            end else if (wr_status && wdata[0]) begin
                expired <= 1'b0;
            end

            tick_out <= expire;
        end
    end

endmodule

// File: rtl/apb_timer_slave.sv
// APB completer for the down-counting timer: setup/access FSM with WAIT_STATES
// inserted wait cycles and register decode. Optional PRESC via APB_TIMER_PRESCALE_EN.
module apb_timer_slave
    import apb_timer_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned CNT_W       = 32
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [31:0] PADDR,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        irq,
    output logic        tick_out
);

    bus_state_e          state_q;
    bus_state_e          state_d;
    logic [WCNT_W-1:0]   wcnt_q;
    logic [WCNT_W-1:0]   wcnt_d;
    logic                pready_d;

    logic                complete_c;
    logic                wr_c;
    logic [2:0]          idx;
    logic [DATA_W-1:0]   rdata_c;

    logic [CTRL_W-1:0]   ctrl;
    logic [CNT_W-1:0]    load_val;
    logic [CNT_W-1:0]    count;
    logic                expired;
    logic [PRESC_W-1:0]  presc;

    logic                unused_paddr;
    assign unused_paddr = ^{PADDR[31:5], PADDR[1:0]};

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
            PREADY  <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            PREADY  <= pready_d;
        end
    end

    // PREADY is registered, so it is precomputed as (next wcnt == 0) while staying in ACCESS
    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        pready_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_d  = ST_ACCESS;
                    wcnt_d   = WCNT_W'(WAIT_STATES);
                    pready_d = (WAIT_STATES == 0);
                end
            end
            ST_ACCESS: begin
                if (!PSEL || (PENABLE && PREADY)) begin
                    state_d = ST_IDLE;
                end else begin
                    if (wcnt_q != '0) begin
                        wcnt_d = wcnt_q - WCNT_W'(1);
                    end
                    pready_d = (wcnt_q <= WCNT_W'(1));
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign complete_c = (state_q == ST_ACCESS) && PSEL && PENABLE && PREADY;
    assign wr_c       = complete_c && PWRITE;
    assign idx        = PADDR[4:2];

    always_comb begin
        rdata_c = '0;
        case (idx)
            OFF_CTRL:   rdata_c = DATA_W'(ctrl);
            OFF_LOAD:   rdata_c = DATA_W'(load_val);
            OFF_COUNT:  rdata_c = DATA_W'(count);
            OFF_STATUS: rdata_c = DATA_W'(expired);
            OFF_PRESC:  rdata_c = DATA_W'(presc);
            default:    rdata_c = '0;
        endcase
    end

    // Read data is driven only in the completing cycle of a read
    assign PRDATA = (complete_c && !PWRITE) ? rdata_c : '0;
    assign irq    = expired && ctrl[CTRL_IRQ_EN];

    apb_timer_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .clk       (PCLK),
        .rst       (PRESET),
        .wr_ctrl   (wr_c && (idx == OFF_CTRL)),
        .wr_load   (wr_c && (idx == OFF_LOAD)),
        .wr_status (wr_c && (idx == OFF_STATUS)),
        .wr_presc  (wr_c && (idx == OFF_PRESC)),
        .wdata     (PWDATA),
        .ctrl      (ctrl),
        .load_val  (load_val),
        .count     (count),
        .expired   (expired),
        .presc     (presc),
        .tick_out  (tick_out)
    );

endmodule

// File: tb/tb_apb_timer_slave.sv
// Scoreboard bench for apb_timer_slave: two instances (0 and 3 wait states), a
// cycle-level timer model in the bench, and a monitor that checks bus completions.
module tb_apb_timer_slave;

    localparam int unsigned WS0 = 0;
    localparam int unsigned WS1 = 3;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [31:0] paddr [2];
    logic [31:0] pwdata [2];
    logic [31:0] prdata [2];
    logic        psel [2];
    logic        penable [2];
    logic        pwrite [2];
    logic        pready [2];
    logic        irq [2];
    logic        tick_out [2];

    always #5 PCLK = ~PCLK;

    apb_timer_slave #(.WAIT_STATES(WS0), .CNT_W(32)) u_dut0 (
        .PCLK(PCLK), .PRESET(PRESET), .PADDR(paddr[0]), .PSEL(psel[0]),
        .PENABLE(penable[0]), .PWRITE(pwrite[0]), .PWDATA(pwdata[0]),
        .PRDATA(prdata[0]), .PREADY(pready[0]), .irq(irq[0]), .tick_out(tick_out[0])
    );

    apb_timer_slave #(.WAIT_STATES(WS1), .CNT_W(32)) u_dut1 (
        .PCLK(PCLK), .PRESET(PRESET), .PADDR(paddr[1]), .PSEL(psel[1]),
        .PENABLE(penable[1]), .PWRITE(pwrite[1]), .PWDATA(pwdata[1]),
        .PRDATA(prdata[1]), .PREADY(pready[1]), .irq(irq[1]), .tick_out(tick_out[1])
    );

    typedef struct {
        logic        is_wr;
        logic [31:0] data;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int checks = 0;
    int errors = 0;
    int wait_n [2];
    logic mon_on = 1'b0;
    logic rst_q;

    // Reference timer state, one set per instance
    logic [2:0]  m_ctrl [2];
    logic [31:0] m_load [2];
    logic [31:0] m_count [2];
    logic        m_expired [2];
    logic [15:0] m_presc [2];
    logic [15:0] m_pcnt [2];
    logic        exp_tick [2];
    logic        exp_irq [2];
    logic        c_wr [2];
    logic [2:0]  c_off [2];
    logic [31:0] c_data [2];

    function automatic int ws(input int d);
        return (d == 0) ? int'(WS0) : int'(WS1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input int d, input logic [2:0] off);
        case (off)
            3'd0: return {29'd0, m_ctrl[d]};
            3'd1: return m_load[d];
            3'd2: return m_count[d];
            3'd3: return {31'd0, m_expired[d]};
`ifdef APB_TIMER_PRESCALE_EN
            3'd4: return {16'd0, m_presc[d]};
`endif
            default: return 32'd0;
        endcase
    endfunction

    // One clock of timer behaviour, applying any bus write that completes this cycle
    task automatic model_update();
        for (int d = 0; d < 2; d++) begin
            logic tk, ex, en, ar;
            if (PRESET) begin
                m_ctrl[d] = '0; m_load[d] = '0; m_count[d] = '0; m_expired[d] = 1'b0;
                m_presc[d] = '0; m_pcnt[d] = '0; exp_tick[d] = 1'b0; exp_irq[d] = 1'b0;
            end else begin
                en = m_ctrl[d][0];
                ar = m_ctrl[d][1];
`ifdef APB_TIMER_PRESCALE_EN
                tk = en && (m_pcnt[d] == m_presc[d]);
`else
                tk = en;
`endif
                ex = tk && (m_count[d] == 32'd0);
                m_pcnt[d] = (!en || tk) ? 16'd0 : 16'(m_pcnt[d] + 16'd1);
                if (c_wr[d] && c_off[d] == 3'd1) begin
                    m_load[d]  = c_data[d];
                    m_count[d] = c_data[d];
                end else if (tk) begin
                    if (m_count[d] != 32'd0) m_count[d] = m_count[d] - 32'd1;
                    else if (ar)             m_count[d] = m_load[d];
                end
                if (c_wr[d] && c_off[d] == 3'd0) m_ctrl[d] = c_data[d][2:0];
                else if (ex && !ar)              m_ctrl[d][0] = 1'b0;
                if (ex) m_expired[d] = 1'b1;
                else if (c_wr[d] && c_off[d] == 3'd3 && c_data[d][0]) m_expired[d] = 1'b0;
`ifdef APB_TIMER_PRESCALE_EN
                if (c_wr[d] && c_off[d] == 3'd4) m_presc[d] = c_data[d][15:0];
`endif
                exp_tick[d] = ex;
                exp_irq[d]  = m_expired[d] && m_ctrl[d][2];
            end
        end
    endtask

    task automatic cycle();
        @(posedge PCLK);
        model_update();
        c_wr[0] = 1'b0;
        c_wr[1] = 1'b0;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic push_exp(input int d, input exp_t e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic xfer(input int d, input logic wr, input logic [2:0] off, input logic [31:0] data);
        logic [31:0] a;
        exp_t e;
        a = $urandom();
        a[4:2] = off;
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = data;
        cycle();
        penable[d] = 1'b1;
        for (int i = 0; i < ws(d); i++) cycle();
        e.is_wr = wr;
        e.data  = wr ? 32'd0 : model_read(d, off);
        push_exp(d, e);
        if (wr) begin
            c_wr[d] = 1'b1; c_off[d] = off; c_data[d] = data;
        end
        cycle();
        psel[d] = 1'b0; penable[d] = 1'b0;
    endtask

    // Start a write and withdraw PSEL before the wait states elapse
    task automatic xfer_abort(input int d, input logic [2:0] off, input logic [31:0] data);
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = 1'b1; paddr[d] = {27'd0, off, 2'b00};
        pwdata[d] = data;
        cycle();
        penable[d] = 1'b1;
        idle(2);
        psel[d] = 1'b0; penable[d] = 1'b0;
        cycle();
    endtask

    function automatic logic [31:0] rand_data(input logic [2:0] off);
        case (off)
            3'd0:    return 32'($urandom_range(0, 7));
            3'd1:    return 32'($urandom_range(0, 6));
            3'd3:    return 32'($urandom_range(0, 1));
            3'd4:    return 32'($urandom_range(0, 3));
            default: return $urandom();
        endcase
    endfunction

    always @(posedge PCLK) rst_q <= PRESET;

    // Monitor: pops the scoreboard on every completed transfer, tracks wait cycles
    always @(negedge PCLK) begin
        exp_t e;
        logic have;
        if (mon_on) begin
            for (int d = 0; d < 2; d++) begin
                if (rst_q) begin
                    chk("reset_pready", 32'(pready[d]), 32'd0);
                    chk("reset_prdata", prdata[d], 32'd0);
                    chk("reset_irq", 32'(irq[d]), 32'd0);
                    chk("reset_tick_out", 32'(tick_out[d]), 32'd0);
                    wait_n[d] = 0;
                end else begin
                    chk("irq", 32'(irq[d]), 32'(exp_irq[d]));
                    chk("tick_out", 32'(tick_out[d]), 32'(exp_tick[d]));
                    if (psel[d] && penable[d]) begin
                        if (pready[d]) begin
                            have = 1'b0;
                            if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                            if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                            if (!have) chk("unexpected_completion", 32'd1, 32'd0);
                            else if (!e.is_wr) chk("prdata", prdata[d], e.data);
                            chk("wait_cycles", 32'(wait_n[d]), 32'(ws(d)));
                            wait_n[d] = 0;
                        end else begin
                            wait_n[d]++;
                        end
                    end else begin
                        wait_n[d] = 0;
                        if (psel[d]) chk("setup_pready", 32'(pready[d]), 32'd0);
                    end
                end
            end
        end
    end

    initial begin
        logic [2:0] off;
        int d;
        PRESET = 1'b1;
        for (int i = 0; i < 2; i++) begin
            psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0;
            paddr[i] = '0; pwdata[i] = '0; c_wr[i] = 1'b0; c_off[i] = '0; c_data[i] = '0;
        end
        idle(3);
        PRESET = 1'b0;
        mon_on = 1'b1;

        // Reset values on every offset, both wait-state configurations
        for (int i = 0; i < 8; i++) xfer(0, 1'b0, 3'(i), 32'd0);
        for (int i = 0; i < 8; i++) xfer(1, 1'b0, 3'(i), 32'd0);

        // LOAD write with wait states, COUNT follows
        xfer(1, 1'b1, 3'd1, 32'd5);
        xfer(1, 1'b0, 3'd2, 32'd0);
        xfer(1, 1'b0, 3'd1, 32'd0);

        // One-shot expiry with interrupt
        xfer(1, 1'b1, 3'd1, 32'd2);
        xfer(1, 1'b1, 3'd0, 32'd5);
        idle(1);
        xfer(1, 1'b0, 3'd2, 32'd0);
        idle(4);
        xfer(1, 1'b0, 3'd3, 32'd0);
        xfer(1, 1'b0, 3'd0, 32'd0);
        xfer(1, 1'b1, 3'd3, 32'd1);
        xfer(1, 1'b0, 3'd3, 32'd0);

        // Auto-reload; W1C issued at varying phases against the 2-cycle expiry period
        xfer(1, 1'b1, 3'd1, 32'd1);
        xfer(1, 1'b1, 3'd0, 32'd7);
        for (int k = 0; k < 4; k++) begin
            idle(k);
            xfer(1, 1'b1, 3'd3, 32'd1);
            xfer(1, 1'b0, 3'd3, 32'd0);
            xfer(1, 1'b0, 3'd2, 32'd0);
        end

        // Withdrawn write must not commit
        xfer(1, 1'b1, 3'd0, 32'd0);
        xfer(1, 1'b1, 3'd1, 32'd7);
        xfer_abort(1, 3'd1, 32'd9);
        xfer(1, 1'b0, 3'd1, 32'd0);
        xfer(1, 1'b0, 3'd2, 32'd0);

        // Prescaler register / offset 0x10
        xfer(1, 1'b0, 3'd4, 32'd0);
        xfer(1, 1'b1, 3'd4, 32'd3);
        xfer(1, 1'b0, 3'd4, 32'd0);
        xfer(1, 1'b1, 3'd1, 32'd1);
        xfer(1, 1'b1, 3'd0, 32'd3);
        for (int k = 0; k < 4; k++) begin
            idle(k);
            xfer(1, 1'b0, 3'd2, 32'd0);
        end

        // Reset in the middle of an access phase
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'h4; pwdata[1] = 32'd3;
        cycle();
        penable[1] = 1'b1;
        cycle();
        PRESET = 1'b1; psel[1] = 1'b0; penable[1] = 1'b0;
        cycle();
        PRESET = 1'b0;
        xfer(1, 1'b0, 3'd1, 32'd0);
        xfer(1, 1'b0, 3'd0, 32'd0);

        // Randomized traffic with occasional back-to-back transfers
        for (int n = 0; n < 200; n++) begin
            d   = ($urandom_range(0, 3) == 0) ? 0 : 1;
            off = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) xfer(d, 1'b1, off, rand_data(off));
            else                           xfer(d, 1'b0, off, 32'd0);
            idle(int'($urandom_range(0, 3)));
        end

        idle(3);
        chk("sb_drain_dut0", 32'(q0.size()), 32'd0);
        chk("sb_drain_dut1", 32'(q1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
